// File: rtl/pll_drp_pkg.sv
// Shared encodings for the PLL dynamic-reconfiguration master:
// MD port opcodes, host command opcodes, FSM states and widths.
package pll_drp_pkg;

  localparam int MD_DW = 8;
  localparam int TMO_W = 16;

  // MDOPC encodings driven towards the PLL wrapper
  localparam logic [1:0] OPC_NOP  = 2'b00;
  localparam logic [1:0] OPC_WR   = 2'b01;
  localparam logic [1:0] OPC_RD   = 2'b10;
  localparam logic [1:0] OPC_ADDR = 2'b11;

  // Host command opcodes on cmd_op_i
  localparam logic [1:0] CMD_RD    = 2'd0;
  localparam logic [1:0] CMD_WR    = 2'd1;
  localparam logic [1:0] CMD_APPLY = 2'd2;
  localparam logic [1:0] CMD_WRINC = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_RD_OP,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_RST,
    ST_WAIT_LOCK,
    ST_RESP
  } state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the PLL lock indication into the clk domain.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability a full cycle to settle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_drp_master.sv
// Host-command to PLL MD-port sequencer: address/write/read sequences,
// read-data capture, and the reset-then-wait-for-lock "apply" operation.
module pll_drp_master
  import pll_drp_pkg::*;
#(
  parameter int RD_LAT       = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [7:0]       cmd_addr_i,
  input  logic [MD_DW-1:0] cmd_wdata_i,
  output logic             rsp_valid_o,
  output logic [MD_DW-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic [1:0]       md_opc_o,
  output logic             md_ainc_o,
  output logic [MD_DW-1:0] md_wdi_o,
  input  logic [MD_DW-1:0] md_rdo_i,
  output logic             pll_reset_o,
  input  logic             pll_lock_i
);

  // Terminal counts for the three timed states
  localparam logic [TMO_W-1:0] RD_LAST  = TMO_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [TMO_W-1:0] RST_LAST = TMO_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] LOCK_IGNORE = TMO_W'(2);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             is_rd_q;
  logic [MD_DW-1:0] wdata_q;
  logic             accept;
  logic             tmo_hit;
  logic             lock_sync;

  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [MD_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic [1:0]       md_opc_q, md_opc_d;
  logic             md_ainc_q, md_ainc_d;
  logic [MD_DW-1:0] md_wdi_q, md_wdi_d;
  logic             pll_reset_q, pll_reset_d;

  pll_lock_sync u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(pll_lock_i),
    .sync_o (lock_sync)
  );

  // State, shared cycle counter and the command fields needed after acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        is_rd_q <= (cmd_op_i == CMD_RD);
        wdata_q <= cmd_wdata_i;
      end
    end
  end

  // Next-state logic; the counter restarts from zero on every state change
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          accept = 1'b1;
          case (cmd_op_i)
            CMD_RD, CMD_WR: state_d = ST_ADDR;
            CMD_WRINC:      state_d = ST_WRITE;
            default:        state_d = ST_RST;
          endcase
        end
      end
      ST_ADDR:    state_d = is_rd_q ? ST_RD_OP : ST_WRITE;
      ST_WRITE:   state_d = ST_RESP;
      ST_RD_OP:   state_d = (RD_LAT > 1) ? ST_RD_WAIT : ST_RD_CAP;
      ST_RD_WAIT: if (cnt_q == RD_LAST) state_d = ST_RD_CAP;
      ST_RD_CAP:  state_d = ST_RESP;
      ST_RST:     if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // A stale lock is masked for the first two cycles; lock beats timeout
        if ((cnt_q >= LOCK_IGNORE) && lock_sync) begin
          state_d = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RESP;
          tmo_hit = 1'b1;
        end
      end
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    cnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_RD_WAIT) || (state_q == ST_RST) || (state_q == ST_WAIT_LOCK)))
      cnt_d = cnt_q + 1'b1;
  end

  // Output decode from the upcoming state so every port comes straight off a flop
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = tmo_hit;
    pll_reset_d = (state_d == ST_RST);
    rsp_rdata_d = (state_q == ST_RD_CAP) ? md_rdo_i : rsp_rdata_q;
    md_opc_d    = OPC_NOP;
    md_ainc_d   = 1'b0;
    md_wdi_d    = md_wdi_q;
    unique case (state_d)
      ST_ADDR: begin
        md_opc_d = OPC_ADDR;
        md_wdi_d = cmd_addr_i;
      end
      ST_WRITE: begin
        md_opc_d  = OPC_WR;
        md_wdi_d  = (state_q == ST_IDLE) ? cmd_wdata_i : wdata_q;
        md_ainc_d = (state_q == ST_IDLE);
      end
      ST_RD_OP: md_opc_d = OPC_RD;
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      md_opc_q    <= OPC_NOP;
      md_ainc_q   <= 1'b0;
      md_wdi_q    <= '0;
      pll_reset_q <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      md_opc_q    <= md_opc_d;
      md_ainc_q   <= md_ainc_d;
      md_wdi_q    <= md_wdi_d;
      pll_reset_q <= pll_reset_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;
  assign md_opc_o    = md_opc_q;
  assign md_ainc_o   = md_ainc_q;
  assign md_wdi_o    = md_wdi_q;
  assign pll_reset_o = pll_reset_q;

endmodule

// File: tb/tb_pll_drp_master.sv
// Testbench for pll_drp_master: a behavioural PLL register file on the MD
// port, a command-level expectation model and lock/timeout scenarios.
module tb_pll_drp_master;

  localparam int RdLat       = 2;
  localparam int RstCycles   = 16;
  localparam int LockTimeout = 100;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdOp;
  logic [7:0] cmdAddr;
  logic [7:0] cmdWdata;
  logic       rspValid;
  logic [7:0] rspRdata;
  logic       rspErr;
  logic       busy;
  logic [1:0] mdOpc;
  logic       mdAinc;
  logic [7:0] mdWdi;
  logic [7:0] mdRdo;
  logic       pllReset;
  logic       pllLock;

  int checks = 0;
  int errors = 0;

  // PLL-side register file reacting to the MD port
  logic [7:0] pllMem [256];
  logic [7:0] pllPtr;
  logic [7:0] rdPipe [RdLat];
  logic       memInit = 1'b0;

  // Command-level expectation: register contents, address pointer, last read
  logic [7:0] expMem [256];
  logic [7:0] expPtr;
  logic [7:0] expRdata;

  pll_drp_master #(
    .RD_LAT      (RdLat),
    .RST_CYCLES  (RstCycles),
    .LOCK_TIMEOUT(LockTimeout)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_op_i   (cmdOp),
    .cmd_addr_i (cmdAddr),
    .cmd_wdata_i(cmdWdata),
    .rsp_valid_o(rspValid),
    .rsp_rdata_o(rspRdata),
    .rsp_err_o  (rspErr),
    .busy_o     (busy),
    .md_opc_o   (mdOpc),
    .md_ainc_o  (mdAinc),
    .md_wdi_o   (mdWdi),
    .md_rdo_i   (mdRdo),
    .pll_reset_o(pllReset),
    .pll_lock_i (pllLock)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  // PLL register file: load-address, write with optional increment, and a
  // read whose data shows up RdLat cycles later (junk at every other time)
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) pllMem[i] <= initVal(8'(i));
      memInit <= 1'b1;
    end else begin
      case (mdOpc)
        2'b11: pllPtr <= mdWdi;
        2'b01: begin
          pllMem[pllPtr] <= mdWdi;
          if (mdAinc) pllPtr <= pllPtr + 8'd1;
        end
        default: ;
      endcase
    end
    rdPipe[0] <= (mdOpc == 2'b10) ? pllMem[pllPtr] : 8'($urandom);
    for (int i = 1; i < RdLat; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign mdRdo = rdPipe[RdLat-1];

  // Single comparison point: counts every check and reports any miss
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReady(input string tag);
    int waitCnt;
    waitCnt = 0;
    while (cmdReady !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput(tag, 32'(cmdReady), 32'd1);
  endtask

  // Issue one MD command (READ, WRITE or WRITE_INC) and check its sequence
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                               input logic [7:0] data);
    int k, rspAt, nonNop, aincCnt, expLat;
    logic [1:0] opc1, opc2;
    logic [7:0] wdi1, wdi2, rdSeen;
    logic ainc1, errSeen;
    waitReady("cmd_ready_before");
    cmdValid = 1'b1; cmdOp = op; cmdAddr = addr; cmdWdata = data;
    @(negedge clk);
    cmdValid = 1'b0; cmdOp = 2'($urandom); cmdAddr = 8'($urandom); cmdWdata = 8'($urandom);
    rspAt = -1; nonNop = 0; aincCnt = 0;
    opc1 = 'x; opc2 = 'x; wdi1 = 'x; wdi2 = 'x; ainc1 = 'x; errSeen = 'x; rdSeen = 'x;
    for (k = 1; k <= 20 && rspAt < 0; k++) begin
      if (k == 1) begin opc1 = mdOpc; wdi1 = mdWdi; ainc1 = mdAinc; end
      if (k == 2) begin opc2 = mdOpc; wdi2 = mdWdi; end
      if (mdOpc != 2'b00) nonNop++;
      if (mdAinc) aincCnt++;
      if (rspValid) begin
        rspAt = k; errSeen = rspErr; rdSeen = rspRdata;
      end else begin
        @(negedge clk);
      end
    end
    case (op)
      2'd1: begin
        expLat = 3;
        checkOutput("wr_opc_t1", 32'(opc1), 32'd3);
        checkOutput("wr_wdi_t1", 32'(wdi1), 32'(addr));
        checkOutput("wr_opc_t2", 32'(opc2), 32'd1);
        checkOutput("wr_wdi_t2", 32'(wdi2), 32'(data));
        checkOutput("wr_ainc_cycles", 32'(aincCnt), 32'd0);
        checkOutput("wr_md_cycles", 32'(nonNop), 32'd2);
        expMem[addr] = data;
        expPtr = addr;
      end
      2'd3: begin
        expLat = 2;
        checkOutput("wrinc_opc_t1", 32'(opc1), 32'd1);
        checkOutput("wrinc_wdi_t1", 32'(wdi1), 32'(data));
        checkOutput("wrinc_ainc_t1", 32'(ainc1), 32'd1);
        checkOutput("wrinc_ainc_cycles", 32'(aincCnt), 32'd1);
        checkOutput("wrinc_md_cycles", 32'(nonNop), 32'd1);
        expMem[expPtr] = data;
        expPtr = expPtr + 8'd1;
      end
      default: begin
        expLat = 3 + RdLat;
        checkOutput("rd_opc_t1", 32'(opc1), 32'd3);
        checkOutput("rd_wdi_t1", 32'(wdi1), 32'(addr));
        checkOutput("rd_opc_t2", 32'(opc2), 32'd2);
        checkOutput("rd_ainc_cycles", 32'(aincCnt), 32'd0);
        checkOutput("rd_md_cycles", 32'(nonNop), 32'd2);
        expRdata = expMem[addr];
        expPtr = addr;
      end
    endcase
    checkOutput("rsp_latency", 32'(rspAt), 32'(expLat));
    checkOutput("rsp_err", 32'(errSeen), 32'd0);
    checkOutput("rsp_rdata", 32'(rdSeen), 32'(expRdata));
    @(negedge clk);
    checkOutput("rsp_single_pulse", 32'(rspValid), 32'd0);
    checkOutput("ready_after_rsp", 32'(cmdReady), 32'd1);
  endtask

  // APPLY: PLL lock rises lockDelay cycles after reset release (never if
  // negative); keepLock leaves a lock high across the whole reset
  task automatic runApply(input int lockDelay, input bit keepLock);
    int k, highCnt, firstHigh, relAt, rspAt, usable, expRel;
    logic errSeen, expErr;
    if (keepLock) pllLock = 1'b1;
    waitReady("apply_ready_before");
    cmdValid = 1'b1; cmdOp = 2'd2; cmdAddr = 8'($urandom); cmdWdata = 8'($urandom);
    @(negedge clk);
    cmdValid = 1'b0;
    highCnt = 0; firstHigh = -1; relAt = -1; rspAt = -1; errSeen = 'x;
    for (k = 1; k <= LockTimeout + RstCycles + 20 && rspAt < 0; k++) begin
      if (pllReset) begin
        highCnt++;
        if (firstHigh < 0) firstHigh = k;
        if (!keepLock) pllLock = 1'b0;
      end else if (firstHigh >= 0 && relAt < 0) begin
        relAt = k;
      end
      if (!keepLock && lockDelay >= 0 && relAt >= 0 && k == relAt + lockDelay) pllLock = 1'b1;
      if (rspValid) begin
        rspAt = k; errSeen = rspErr;
      end else begin
        @(negedge clk);
      end
    end
    // Lock is usable two cycles after it rises, never before wait-cycle 2
    if (keepLock) usable = 2;
    else if (lockDelay < 0) usable = 1 << 20;
    else usable = (lockDelay + 2 < 2) ? 2 : lockDelay + 2;
    if (usable <= LockTimeout - 1) begin
      expErr = 1'b0; expRel = usable + 1;
    end else begin
      expErr = 1'b1; expRel = LockTimeout;
    end
    checkOutput("apply_reset_start", 32'(firstHigh), 32'd1);
    checkOutput("apply_reset_len", 32'(highCnt), 32'(RstCycles));
    checkOutput("apply_rsp_after_release", 32'(rspAt - relAt), 32'(expRel));
    checkOutput("apply_rsp_err", 32'(errSeen), 32'(expErr));
    checkOutput("apply_rdata_held", 32'(rspRdata), 32'(expRdata));
    @(negedge clk);
    checkOutput("apply_single_pulse", 32'(rspValid), 32'd0);
    checkOutput("apply_ready_after", 32'(cmdReady), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sawRsp, sel, dly;
    rstN = 1'b0; cmdValid = 1'b0; cmdOp = 2'd0; cmdAddr = 8'd0; cmdWdata = 8'd0;
    pllLock = 1'b0; expRdata = 8'd0; expPtr = 8'd0;
    for (int i = 0; i < 256; i++) expMem[i] = initVal(8'(i));
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rspRdata), 32'd0);
    checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("rst_md_opc", 32'(mdOpc), 32'd0);
    checkOutput("rst_md_ainc", 32'(mdAinc), 32'd0);
    checkOutput("rst_md_wdi", 32'(mdWdi), 32'd0);
    checkOutput("rst_pll_reset", 32'(pllReset), 32'd0);
    rstN = 1'b1;

    $display("[TB] directed write / read / write-increment");
    applyStimulus(2'd1, 8'h2A, 8'h5C);
    applyStimulus(2'd1, 8'h10, 8'hA7);
    applyStimulus(2'd0, 8'h10, 8'h00);
    applyStimulus(2'd1, 8'h2B, 8'h66);
    applyStimulus(2'd0, 8'h10, 8'h00);
    applyStimulus(2'd3, 8'hFF, 8'h01);
    applyStimulus(2'd3, 8'hFF, 8'h02);
    applyStimulus(2'd3, 8'hFF, 8'h03);
    applyStimulus(2'd0, 8'h12, 8'h00);
    applyStimulus(2'd0, 8'h2A, 8'h00);

    $display("[TB] apply: lock, timeout, lock/timeout boundary, stale lock");
    runApply(40, 1'b0);
    runApply(-1, 1'b0);
    runApply(97, 1'b0);
    runApply(98, 1'b0);
    runApply(0, 1'b1);

    $display("[TB] async reset during read wait");
    waitReady("midrd_ready");
    cmdValid = 1'b1; cmdOp = 2'd0; cmdAddr = 8'h33;
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrd_busy_before", 32'(busy), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midrd_md_opc", 32'(mdOpc), 32'd0);
    checkOutput("midrd_busy", 32'(busy), 32'd0);
    checkOutput("midrd_cmd_ready", 32'(cmdReady), 32'd0);
    checkOutput("midrd_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("midrd_rsp_rdata", 32'(rspRdata), 32'd0);
    sawRsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rspValid) sawRsp++;
    end
    rstN = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rspValid) sawRsp++;
    end
    checkOutput("midrd_no_rsp", 32'(sawRsp), 32'd0);
    expPtr = 8'h33;
    expRdata = 8'h00;
    applyStimulus(2'd0, 8'h33, 8'h00);

    $display("[TB] randomized command mix");
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) applyStimulus(2'd1, 8'($urandom_range(0, 15)), 8'($urandom));
      else if (sel <= 6) applyStimulus(2'd0, 8'($urandom_range(0, 15)), 8'($urandom));
      else if (sel <= 8) applyStimulus(2'd3, 8'($urandom), 8'($urandom));
      else begin
        dly = $urandom_range(0, 60);
        runApply(dly, 1'b0);
      end
    end
    for (int a = 0; a < 16; a++) applyStimulus(2'd0, 8'(a), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
